freq_div_n: RTL and testbench
=============================

Name: freq_div_n

Overview:
- Parametrised successor of the fixed divide-by-2 divider.
- Divides clk by a runtime-programmable integer divisor D and produces a divided clock-enable style square wave plus a one-cycle period tick.
- Used where peripheral timing needs rates other than clk/2 (UART baud, LED scan, sample strobes).
- Divisor changes take effect only at period boundaries, so frequency never glitches.

Parameters:
- WIDTH, 8, width of divisor and internal counter; D range 0..2^WIDTH-1
- RESET_DIV, 2, divisor value loaded into the active-divisor register at reset

Ports:
- clk  in  1  system clock; all logic on rising edge except the optional feature
- reset  in  1  synchronous, active-high reset
- enable  in  1  count enable; low freezes counter and output
- divisor  in  WIDTH  requested divisor D; sampled only at period boundaries or in IDLE
- frequency  out  1  divided output, period D clk cycles
- tick  out  1  one-cycle pulse on the first cycle of every output period
- div_active  out  WIDTH  divisor currently in effect (after D=1 to 2 mapping)

Behaviour:
- Effective divisor De: divisor=0 means stopped; divisor=1 is mapped to 2; otherwise De=divisor.
- Registers: state (IDLE/RUN), cnt[WIDTH-1:0], div_q[WIDTH-1:0], frequency, tick. All outputs are registered, except in the optional-feature build.
- Reset, on a clk edge with reset=1: state=IDLE, cnt=0, frequency=0, tick=0, div_q=RESET_DIV. Reset has priority over enable. Reset mid-period aborts the period immediately.
- High-phase length H = floor(De/2). Low phase = De-H. Even De gives a 50% duty cycle. Odd De, base build, is high for (De-1)/2 cycles and low for (De+1)/2 cycles.
- IDLE state:
  - frequency=0, tick=0, cnt=0. div_q follows divisor (mapped) on every edge.
  - On an edge with enable=1 and divisor!=0: go to RUN, cnt<=0, frequency<=1, tick<=1, div_q<=mapped divisor.
- RUN state, enable=1:
  - If cnt==div_q-1, this is the period end:
    - cnt<=0 and tick<=1.
    - Sample divisor. If divisor==0, go to IDLE with frequency<=0 and tick<=0.
    - Otherwise div_q<=mapped divisor and frequency<=1.
  - Else: cnt<=cnt+1, tick<=0, frequency<=(cnt+1 < H).
- RUN state, enable=0: cnt, div_q, state and frequency hold; tick<=0. On re-enable, counting resumes from the held cnt with no period restart.
- Divisor changes mid-period are ignored until the period end.
- div_active = div_q at all times.
- Latency: the first rising edge of frequency and the first tick occur on the first enabled edge after reset release, 1 cycle.
- Counter wrap: cnt never exceeds div_q-1. De=2^WIDTH-1 is legal. No arithmetic overflow, because comparisons use div_q-1 computed at WIDTH bits and div_q>=2.

Optional Feature:
- Macro: FREQ_DIV_N_ODD_DUTY50_EN
- Defined:
  - Adds a falling-edge register neg_ph. It samples the internal posedge high-phase register on the falling edge of clk and clears on a falling edge while reset=1.
  - For odd De, frequency = pos_ph | neg_ph. This gives a high time of exactly De/2 clk periods, i.e. a 50% duty cycle.
  - Even De is unchanged (neg_ph gated off).
  - frequency is then a combinational OR output.
  - tick is unaffected.
- Not defined: no negedge logic; frequency is purely posedge-registered with the odd-D duty cycle given above.

Test Plan:
- Reset, divisor=4, enable=1 for 16 cycles: frequency pattern 1100 repeating; tick high on cycles 0,4,8,12; div_active=4.
- divisor=5, base build: frequency pattern 11000 (high 2, low 3), period 5. With FREQ_DIV_N_ODD_DUTY50_EN defined, high time measures 2.5 clk periods.
- divisor changed 4 to 6 at cnt=1: the current period completes at length 4; the next periods are 6 long (111000); div_active changes on the tick cycle.
- divisor=1 gives behaviour identical to divisor=2 (pattern 10, tick every 2 cycles). divisor=0 at a period end goes to IDLE with frequency=0 and tick=0; setting divisor=3 restarts with tick on the next enabled edge.
- enable dropped for 5 cycles at cnt=2 with De=8: outputs frozen and tick=0; after re-enable the period completes after 5 more enabled cycles; total measured period = 13 wall cycles.
- reset asserted at cnt=3 with De=10: next edge gives frequency=0, tick=0, state IDLE, div_active=RESET_DIV=2. After release, the first enabled edge gives tick=1.

Source files
------------

// File: rtl/freq_div_n.sv
// Runtime-programmable clock divider: square wave of period De clk cycles plus a period tick.
// Optional build FREQ_DIV_N_ODD_DUTY50_EN adds a falling-edge stage for 50% duty on odd divisors.
module freq_div_n #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] divisor,
    output logic             frequency,
    output logic             tick,
    output logic [WIDTH-1:0] div_active
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_q;
    logic             pos_ph;

    logic [WIDTH-1:0] div_map;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] last;

    // A divisor of 1 cannot make a square wave, so it runs as divide-by-2.
    assign div_map = (divisor == WIDTH'(1)) ? WIDTH'(2) : divisor;
    assign cnt_inc = cnt + WIDTH'(1);
    assign half    = div_q >> 1;
    assign last    = div_q - WIDTH'(1);

    assign div_active = div_q;

    // NOTE: all state updates use <= so every branch sees the pre-edge values of cnt/div_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            div_q  <= WIDTH'(RESET_DIV);
            pos_ph <= 1'b0;
            tick   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    div_q  <= div_map;
                    pos_ph <= 1'b0;
                    tick   <= 1'b0;
                    if (enable && divisor != '0) begin
                        state  <= RUN;
                        pos_ph <= 1'b1;
                        tick   <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        tick <= 1'b0;
                    end else if (cnt == last) begin
                        // Period boundary: the only place a new divisor is accepted.
                        cnt <= '0;
                        if (divisor == '0) begin
                            state  <= IDLE;
                            pos_ph <= 1'b0;
                            tick   <= 1'b0;
                        end else begin
                            div_q  <= div_map;
                            pos_ph <= 1'b1;
                            tick   <= 1'b1;
                        end
                    end else begin
                        cnt    <= cnt_inc;
                        tick   <= 1'b0;
                        pos_ph <= (cnt_inc < half);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FREQ_DIV_N_ODD_DUTY50_EN
    logic neg_ph;

    // Half-cycle delayed copy stretches the high phase by 0.5 clk for odd divisors.
    always_ff @(negedge clk) begin
        if (reset) neg_ph <= 1'b0;
        else       neg_ph <= pos_ph;
    end

    assign frequency = pos_ph | (neg_ph & div_q[0]);
`else
    assign frequency = pos_ph;
`endif

endmodule

// File: tb/tb_freq_div_n.sv
// Scoreboard bench for freq_div_n: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_freq_div_n;

`ifdef FREQ_DIV_N_ODD_DUTY50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] divisor;
    logic       frequency;
    logic       tick;
    logic [7:0] div_active;

    typedef struct {
        logic       f;
        logic       t;
        logic [7:0] da;
        bit         chk_f;
        bit         chk_da;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   ncmp  = 0;
    int   nfail = 0;
    int   cyc   = 0;
    bit   in_odd5 = 1'b0;

    freq_div_n #(.WIDTH(8), .RESET_DIV(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .divisor    (divisor),
        .frequency  (frequency),
        .tick       (tick),
        .div_active (div_active)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic [7:0] d,
                        input logic f, input logic t, input logic [7:0] da,
                        input bit cf, input bit cda, input string name);
        exp_t x;
        reset   = r;
        enable  = e;
        divisor = d;
        x.f = f; x.t = t; x.da = da; x.chk_f = cf; x.chk_da = cda; x.name = name;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // fp/tp are hand-written frequency/tick strings, one character per clk edge.
    task automatic pat(input logic e, input logic [7:0] d, input string fp, input string tp,
                       input logic [7:0] da, input bit cf, input string name);
        for (int i = 0; i < fp.len(); i++)
            step(1'b0, e, d, fp[i] == "1", tp[i] == "1", da, cf, 1'b1, name);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            ncmp++;
            if (tick !== cur.t) begin
                nfail++;
                $display("FAIL %s tick cyc=%0d actual=%b required=%b", cur.name, cyc, tick, cur.t);
            end
            if (cur.chk_f) begin
                ncmp++;
                if (frequency !== cur.f) begin
                    nfail++;
                    $display("FAIL %s frequency cyc=%0d actual=%b required=%b", cur.name, cyc, frequency, cur.f);
                end
            end
            if (cur.chk_da) begin
                ncmp++;
                if (div_active !== cur.da) begin
                    nfail++;
                    $display("FAIL %s div_active cyc=%0d actual=%0d required=%0d", cur.name, cyc, div_active, cur.da);
                end
            end
        end
    end

`ifdef FREQ_DIV_N_ODD_DUTY50_EN
    realtime t_rise = 0;
    always @(posedge frequency) t_rise = $realtime;
    always @(negedge frequency) begin
        if (in_odd5) begin
            ncmp++;
            if ($realtime - t_rise != 25.0) begin
                nfail++;
                $display("FAIL odd5_high_time actual=%0t required=25", $realtime - t_rise);
            end
        end
    end
`endif

    initial begin
        // Reset, then one idle edge where div_active follows the requested divisor.
        step(1'b1, 1'b0, 8'd4, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, "reset");
        step(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1, "idle_follow");
        pat(1'b1, 8'd4, "1100110011001100", "1000100010001000", 8'd4, 1'b1, "div4");

        // Divisor 4 -> 6 requested at cnt=1; current period still ends at length 4.
        pat(1'b1, 8'd4, "1", "1", 8'd4, 1'b1, "chg_start");
        pat(1'b1, 8'd6, "100", "000", 8'd4, 1'b1, "chg_hold");
        pat(1'b1, 8'd6, "111000111000", "100000100000", 8'd6, 1'b1, "div6");

        // Divisor 1 behaves as 2; divisor 0 at period end returns to IDLE.
        pat(1'b1, 8'd1, "101010", "101010", 8'd2, 1'b1, "div1");
        step(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, "stop");
        step(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, "idle_zero");
        pat(1'b1, 8'd3, "100100", "100100", 8'd3, !ODD50, "div3");

        // Odd divisor 5: 11000 in the base build.
        in_odd5 = 1'b1;
        pat(1'b1, 8'd5, "1100011000", "1000010000", 8'd5, !ODD50, "div5");
        in_odd5 = 1'b0;

        // De=8, enable dropped for 5 cycles at cnt=2: 13-cycle wall period.
        pat(1'b1, 8'd8, "111", "100", 8'd8, 1'b1, "en_pre");
        pat(1'b0, 8'd8, "11111", "00000", 8'd8, 1'b1, "en_frozen");
        pat(1'b1, 8'd8, "10000", "00000", 8'd8, 1'b1, "en_resume");

        // De=10, reset at cnt=3 aborts the period; restart ticks on first enabled edge.
        pat(1'b1, 8'd10, "1111", "1000", 8'd10, 1'b1, "div10");
        step(1'b1, 1'b1, 8'd10, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, "mid_reset");
        pat(1'b1, 8'd10, "11", "10", 8'd10, 1'b1, "restart");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        ncmp++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
